// File: rtl/multi_cycle_processor.sv
// Multi-cycle RV-subset core: one instruction walks FETCH/DECODE/EXEC/MEM/WB
// through a single shared req/ready memory port, parking in HALT on faults.
module multi_cycle_processor #(
  parameter int unsigned       XLEN      = 64,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter int unsigned       REG_COUNT = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            retire,
  output logic            halted
);

  localparam int unsigned RIDX_W  = $clog2(REG_COUNT);
  localparam int unsigned ALIGN_W = (XLEN == 64) ? 3 : 2;
  localparam logic [2:0]  LS_F3   = (XLEN == 64) ? 3'd3 : 3'd2;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]      state, next_state;
  logic [XLEN-1:0] pc, a, b, imm, res;
  logic [31:0]     ir;
  logic [XLEN-1:0] rf [REG_COUNT];

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic       is_r, is_imm, is_load, is_store, is_branch, is_jal;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign is_r      = (opcode == OP_R);
  assign is_imm    = (opcode == OP_IMM);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BR);
  assign is_jal    = (opcode == OP_JAL);

  logic [XLEN-1:0] imm_c, alu_c, addr_c, target_c, pc_plus4_c;
  logic            taken_c, legal_c, r_legal_c, ls_misaligned_c, target_misaligned_c;

  // Only the listed funct combinations are implemented; everything else (incl. ecall) halts.
  assign r_legal_c = is_r && (((funct7 == 7'h00) && ((funct3 == 3'd0) || (funct3 == 3'd2) ||
                                                     (funct3 == 3'd6) || (funct3 == 3'd7))) ||
                              ((funct7 == 7'h20) && (funct3 == 3'd0)));
  assign legal_c = r_legal_c
                || (is_imm && (funct3 == 3'd0))
                || ((is_load || is_store) && (funct3 == LS_F3))
                || (is_branch && ((funct3 == 3'd0) || (funct3 == 3'd1)))
                || is_jal;

  always_comb begin
    imm_c = {{(XLEN-12){ir[31]}}, ir[31:20]};
    case (opcode)
      OP_STORE: imm_c = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      OP_BR:    imm_c = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_JAL:   imm_c = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:  ;
    endcase
  end

  always_comb begin
    alu_c = a + imm;
    if (is_r) begin
      case ({funct7[5], funct3})
        4'b1_000: alu_c = a - b;
        4'b0_111: alu_c = a & b;
        4'b0_110: alu_c = a | b;
        4'b0_010: alu_c = XLEN'($signed(a) < $signed(b));
        default:  alu_c = a + b;
      endcase
    end
  end

  assign addr_c              = a + imm;
  assign target_c            = pc + imm;
  assign pc_plus4_c          = pc + XLEN'(4);
  assign taken_c             = (funct3 == 3'd0) ? (a == b) : (a != b);
  assign ls_misaligned_c     = |addr_c[ALIGN_W-1:0];
  assign target_misaligned_c = |target_c[1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: next_state = legal_c ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_load || is_store) begin
          next_state = ls_misaligned_c ? S_HALT : S_MEM;
        end else if (is_branch) begin
          if (taken_c && target_misaligned_c) begin
            next_state = S_HALT;
          end else begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
        end else if (is_jal) begin
          next_state = target_misaligned_c ? S_HALT : S_WB;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_load) begin
            next_state = S_WB;
          end else begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
        end
      end
      S_WB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_HALT;
    endcase
  end

  // Datapath; a faulting branch/jal leaves pc on the offending instruction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc  <= RESET_PC;
      ir  <= '0;
      a   <= '0;
      b   <= '0;
      imm <= '0;
      res <= '0;
      for (int i = 0; i < REG_COUNT; i++) rf[RIDX_W'(i)] <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) ir <= mem_rdata[31:0];
        S_DECODE: begin
          a   <= rf[rs1[RIDX_W-1:0]];
          b   <= rf[rs2[RIDX_W-1:0]];
          imm <= imm_c;
        end
        S_EXEC: begin
          if (is_branch) begin
            if (!(taken_c && target_misaligned_c)) pc <= taken_c ? target_c : pc_plus4_c;
          end else if (is_jal) begin
            if (!target_misaligned_c) pc <= target_c;
            res <= pc_plus4_c;
          end else if (is_load || is_store) begin
            res <= addr_c;
          end else begin
            res <= alu_c;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_load) res <= mem_rdata;
            else         pc  <= pc_plus4_c;
          end
        end
        S_WB: begin
          if (rd != 5'd0) rf[rd[RIDX_W-1:0]] <= res;
          if (!is_jal) pc <= pc_plus4_c;
        end
        default: ;
      endcase
    end
  end

  // Request is gated by reset so an abandoned transfer drops without waiting for a clock.
  assign mem_req   = reset_n && ((state == S_FETCH) || (state == S_MEM));
  assign mem_we    = (state == S_MEM) && is_store;
  assign mem_addr  = (state == S_MEM) ? res : pc;
  assign mem_wdata = b;
  assign pc_out    = pc;
  assign halted    = (state == S_HALT);

endmodule
